// File: rtl/id_stage.sv
// LC-3b decode stage: register file with write-through, immediate extender,
// and load-use hazard detection that freezes IF/ID and bubbles ID/EXE for one cycle.
module id_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    input  logic        wb_we,
    input  logic [2:0]  wb_dest,
    input  logic [15:0] wb_data,
    input  logic        exe_valid,
    input  logic        exe_is_load,
    input  logic [2:0]  exe_dest,
    output logic [15:0] sr1_out,
    output logic [15:0] sr2_out,
    output logic [15:0] sext_out,
    output logic        hazard_stall,
    output logic        bubble
);
    typedef enum logic {RUN, HOLD} state_t;

    localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LDB = 4'b0010,
                           OP_STB = 4'b0011, OP_JSR = 4'b0100, OP_AND = 4'b0101,
                           OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001,
                           OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100,
                           OP_SHF = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111;

    state_t            state;
    logic [7:0][15:0]  regs;
    logic [3:0]        opcode;
    logic [2:0]        sr1_addr, sr2_addr;
    logic              is_store, sr1_used, sr2_used, hz;

    assign opcode   = instr[15:12];
    assign is_store = (opcode == OP_STR) || (opcode == OP_STB) || (opcode == OP_STI);
    assign sr1_addr = instr[8:6];
    assign sr2_addr = is_store ? instr[11:9] : instr[2:0];

    // Reads are forced to zero while in reset so the outputs never expose stale contents.
    always_comb begin
        sr1_out = regs[sr1_addr];
        sr2_out = regs[sr2_addr];
        if (wb_we && wb_dest == sr1_addr) sr1_out = wb_data;
        if (wb_we && wb_dest == sr2_addr) sr2_out = wb_data;
        if (reset) begin
            sr1_out = 16'h0000;
            sr2_out = 16'h0000;
        end
    end

    always_comb begin
        sext_out = 16'h0000;
        case (opcode)
            OP_ADD, OP_AND: sext_out = {{11{instr[4]}}, instr[4:0]};
            OP_LDR, OP_STR: sext_out = {{9{instr[5]}}, instr[5:0], 1'b0};
            OP_LDB, OP_STB: sext_out = {{10{instr[5]}}, instr[5:0]};
            OP_BR, OP_LEA:  sext_out = {{6{instr[8]}}, instr[8:0], 1'b0};
            OP_JSR:         if (instr[11]) sext_out = {{4{instr[10]}}, instr[10:0], 1'b0};
            OP_SHF:         sext_out = {12'h000, instr[3:0]};
            OP_TRAP:        sext_out = {7'h00, instr[7:0], 1'b0};
            default:        sext_out = 16'h0000;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_LDR, OP_LDB, OP_LDI,
            OP_STR, OP_STB, OP_STI, OP_JMP: sr1_used = 1'b1;
            OP_JSR:                         sr1_used = ~instr[11];
            default:                        sr1_used = 1'b0;
        endcase
        sr2_used = (((opcode == OP_ADD) || (opcode == OP_AND)) && !instr[5]) || is_store;
        hz = instr_valid && exe_valid && exe_is_load &&
             ((sr1_used && exe_dest == sr1_addr) || (sr2_used && exe_dest == sr2_addr));
    end

    // The hazard is only honoured in RUN; HOLD is the single penalty cycle.
    assign hazard_stall = !reset && state == RUN && hz && !stall_in;
    assign bubble       = hazard_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            regs  <= '0;
        end else begin
            if (wb_we) regs[wb_dest] <= wb_data;
            if (!stall_in) begin
                case (state)
                    RUN:     if (hz) state <= HOLD;
                    HOLD:    state <= RUN;
                    default: state <= RUN;
                endcase
            end
        end
    end
endmodule
